regfile_mp: RTL and testbench

Parametrised multi-port register file for the LEGv8 datapath; successor of the single-cycle two-read/one-write register file. It adds configurable width, depth and port counts, asynchronous reset to a known image, deterministic write-conflict resolution, optional write-to-read bypass for the pipelined core, and a per-register busy scoreboard for hazard detection. It sits between decode (read ports) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_scoreboard.sv | 62 ++++++
 rtl/regfile_mp.sv | 68 ++++++
 tb/tb_regfile_mp.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, types and reset image for regfile_mp
package regfile_pkg;

    localparam int DATA_W_DEF   = 64;
    localparam int ADDR_W_DEF   = 5;
    localparam int NREAD_DEF    = 2;
    localparam int NWRITE_DEF   = 1;
    localparam int ZERO_REG_DEF = 2**ADDR_W_DEF - 1;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    // Reset image: every register holds its own index, the zero register holds 0.
    function automatic reg_data_t init_val(input int unsigned idx, input int unsigned zero_idx);
        return (idx == zero_idx) ? '0 : reg_data_t'(idx);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/claim bus between decode, writeback and regfile_mp
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = NREAD_DEF,
    parameter int NWRITE = NWRITE_DEF
);
    logic [NWRITE-1:0]             we;
    logic [NWRITE-1:0][ADDR_W-1:0] wa;
    logic [NWRITE-1:0][DATA_W-1:0] wd;
    logic [NREAD-1:0][ADDR_W-1:0]  ra;
    logic [NREAD-1:0][DATA_W-1:0]  rd;
    logic                          claim_en;
    logic [ADDR_W-1:0]             claim_addr;
    logic [NREAD-1:0]              rbusy;

    modport master (
        output we, wa, wd, ra, claim_en, claim_addr,
        input  rd, rbusy
    );

    modport slave (
        input  we, wa, wd, ra, claim_en, claim_addr,
        output rd, rbusy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits and rbusy lookup (REGFILE_BYPASS_EN: same-cycle clear)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = NREAD_DEF,
    parameter int NWRITE   = NWRITE_DEF,
    parameter int ZERO_REG = 2**ADDR_W - 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NWRITE-1:0]             i_we,
    input  logic [NWRITE-1:0][ADDR_W-1:0] i_wa,
    input  logic                          i_claim_en,
    input  logic [ADDR_W-1:0]             i_claim_addr,
    input  logic [NREAD-1:0][ADDR_W-1:0]  i_ra,
    output logic [NREAD-1:0]              o_rbusy
);
    localparam int                DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;
    logic             w_claim_ok;

    assign w_claim_ok = i_claim_en && (i_claim_addr != ZADDR);

    // Writes retire a pending destination; a claim on the same edge re-arms it.
    always_comb begin
        w_busy_next = r_busy;
        for (int p = 0; p < NWRITE; p++) begin
            if (i_we[p] && (i_wa[p] != ZADDR))
                w_busy_next[i_wa[p]] = 1'b0;
        end
        if (w_claim_ok)
            w_busy_next[i_claim_addr] = 1'b1;
        w_busy_next[ZADDR] = 1'b0;
    end

    // Busy vector; reset clears every pending claim.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_busy <= '0;
        else
            r_busy <= w_busy_next;
    end

    // Per-port busy lookup; with forwarding a same-cycle write hides the stale busy bit.
    always_comb begin
        o_rbusy = '0;
        for (int i = 0; i < NREAD; i++) begin
            o_rbusy[i] = r_busy[i_ra[i]];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NWRITE; p++) begin
                if (i_we[p] && (i_wa[p] != ZADDR) && (i_wa[p] == i_ra[i]))
                    o_rbusy[i] = w_claim_ok && (i_claim_addr == i_ra[i]);
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with zero register and busy scoreboard (REGFILE_BYPASS_EN: write-to-read forwarding)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = NREAD_DEF,
    parameter int NWRITE   = NWRITE_DEF,
    parameter int ZERO_REG = 2**ADDR_W - 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int                DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]            r_mem [DEPTH];
    logic [NREAD-1:0][DATA_W-1:0] w_rd;
    logic [NREAD-1:0]             w_rbusy;

    // Data array: reset loads the index image; ports apply in ascending order so the highest port wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= DATA_W'(init_val(i, ZERO_REG));
        end else begin
            for (int p = 0; p < NWRITE; p++) begin
                if (bus.we[p] && (bus.wa[p] != ZADDR))
                    r_mem[bus.wa[p]] <= bus.wd[p];
            end
        end
    end

    // Read muxes: zero register forced to 0, optional forwarding from the winning write port.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NREAD; i++) begin
            w_rd[i] = (bus.ra[i] == ZADDR) ? '0 : r_mem[bus.ra[i]];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NWRITE; p++) begin
                if (bus.we[p] && (bus.wa[p] != ZADDR) && (bus.wa[p] == bus.ra[i]))
                    w_rd[i] = bus.wd[p];
            end
`endif
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NREAD    (NREAD),
        .NWRITE   (NWRITE),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .i_we         (bus.we),
        .i_wa         (bus.wa),
        .i_claim_en   (bus.claim_en),
        .i_claim_addr (bus.claim_addr),
        .i_ra         (bus.ra),
        .o_rbusy      (w_rbusy)
    );

    assign bus.rd    = w_rd;
    assign bus.rbusy = w_rbusy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (4 read ports, 2 write ports)
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int NR = 4;
    localparam int NW = 2;
    localparam int ZR = ZERO_REG_DEF;

    typedef struct {
        string       nm;
        int          port;
        logic [63:0] rd;
        logic        busy;
    } chk_t;

    logic clk = 1'b0;
    logic reset;

    regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NREAD(NR), .NWRITE(NW)) bus ();

    regfile_mp #(
        .DATA_W (64), .ADDR_W (5), .NREAD (NR), .NWRITE (NW), .ZERO_REG (ZR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    reg_data_t m_reg  [32];
    logic      m_busy [32];
    chk_t      exp_q [$];
    chk_t      obs_q [$];
    int        n_pass  = 0;
    int        n_total = 0;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = (i == ZR) ? 64'd0 : 64'(i);
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int p = 0; p < NW; p++) begin
            if (bus.we[p] && bus.wa[p] != reg_addr_t'(ZR)) begin
                m_reg[bus.wa[p]]  = bus.wd[p];
                m_busy[bus.wa[p]] = 1'b0;
            end
        end
        if (bus.claim_en && bus.claim_addr != reg_addr_t'(ZR))
            m_busy[bus.claim_addr] = 1'b1;
    endtask

    function automatic logic [63:0] model_rd(input int i);
        reg_addr_t   a = bus.ra[i];
        logic [63:0] v = (a == reg_addr_t'(ZR)) ? 64'd0 : m_reg[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NW; p++)
            if (bus.we[p] && bus.wa[p] != reg_addr_t'(ZR) && bus.wa[p] == a) v = bus.wd[p];
`endif
        return v;
    endfunction

    function automatic logic model_busy(input int i);
        reg_addr_t a = bus.ra[i];
        logic      b = (a == reg_addr_t'(ZR)) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NW; p++)
            if (bus.we[p] && bus.wa[p] != reg_addr_t'(ZR) && bus.wa[p] == a)
                b = bus.claim_en && bus.claim_addr == a && a != reg_addr_t'(ZR);
`endif
        return b;
    endfunction

    // Push the model's expectation and the DUT's current output for one read port.
    task automatic expect_port(input string nm, input int port);
        chk_t e;
        chk_t o;
        e.nm = nm; e.port = port; e.rd = model_rd(port); e.busy = model_busy(port);
        o.nm = nm; o.port = port; o.rd = bus.rd[port];   o.busy = bus.rbusy[port];
        exp_q.push_back(e);
        obs_q.push_back(o);
    endtask

    task automatic idle_inputs();
        bus.we = '0; bus.wa = '0; bus.wd = '0; bus.claim_en = 1'b0; bus.claim_addr = '0;
    endtask

    // One rising edge: model follows the held inputs, then inputs go idle before sampling.
    task automatic cycle();
        @(posedge clk);
        if (!reset) model_update();
        #2;
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        chk_t e;
        chk_t o;
        reset = 1'b1;
        idle_inputs();
        bus.ra = {5'd30, 5'd0, 5'd31, 5'd5};
        model_reset();
        #3;
        for (int i = 0; i < NR; i++) expect_port("reset_image", i);
        @(negedge clk);
        reset = 1'b0;
        bus.we[0] = 1'b1; bus.wa[0] = 5'd5; bus.wd[0] = 64'h1234;
        bus.claim_en = 1'b1; bus.claim_addr = 5'd6;
        bus.ra[1] = 5'd6;
        cycle();
        expect_port("post_reset_write", 0);
        expect_port("post_reset_claim", 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        expect_port("async_revert_data", 0);
        expect_port("async_revert_busy", 1);
        @(negedge clk);
        bus.we[0] = 1'b1; bus.wa[0] = 5'd8; bus.wd[0] = 64'h99; bus.ra[0] = 5'd8;
        cycle();
        expect_port("write_in_reset_dropped", 0);
        @(negedge clk);
        reset = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o.rd !== e.rd || o.busy !== e.busy)
                $display("FAIL %s port%0d: got rd=%h rbusy=%b, expected rd=%h rbusy=%b",
                         e.nm, e.port, o.rd, o.busy, e.rd, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_write_latency();
        chk_t e;
        chk_t o;
        @(negedge clk);
        bus.we[0] = 1'b1; bus.wa[0] = 5'd7; bus.wd[0] = 64'hDEAD; bus.ra[0] = 5'd7;
        #1;
        expect_port("same_cycle_read", 0);
        cycle();
        expect_port("after_edge_read", 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o.rd !== e.rd || o.busy !== e.busy)
                $display("FAIL %s port%0d: got rd=%h rbusy=%b, expected rd=%h rbusy=%b",
                         e.nm, e.port, o.rd, o.busy, e.rd, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_zero_reg();
        chk_t e;
        chk_t o;
        @(negedge clk);
        bus.we[0] = 1'b1; bus.wa[0] = 5'd31; bus.wd[0] = 64'hFFFF; bus.ra[0] = 5'd31;
        #1;
        expect_port("zero_write_same_cycle", 0);
        cycle();
        expect_port("zero_write_dropped", 0);
        @(negedge clk);
        bus.claim_en = 1'b1; bus.claim_addr = 5'd31;
        cycle();
        expect_port("zero_claim_ignored", 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o.rd !== e.rd || o.busy !== e.busy)
                $display("FAIL %s port%0d: got rd=%h rbusy=%b, expected rd=%h rbusy=%b",
                         e.nm, e.port, o.rd, o.busy, e.rd, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_write_conflict();
        chk_t e;
        chk_t o;
        @(negedge clk);
        bus.we = 2'b11; bus.wa[0] = 5'd3; bus.wd[0] = 64'h11; bus.wa[1] = 5'd3; bus.wd[1] = 64'h22;
        bus.ra[0] = 5'd3;
        #1;
        expect_port("conflict_same_cycle", 0);
        cycle();
        expect_port("conflict_port1_wins", 0);
        @(negedge clk);
        bus.we = 2'b11; bus.wa[0] = 5'd4; bus.wd[0] = 64'h44; bus.wa[1] = 5'd10; bus.wd[1] = 64'hAA;
        bus.ra[0] = 5'd4; bus.ra[1] = 5'd10;
        cycle();
        expect_port("dual_write_p0", 0);
        expect_port("dual_write_p1", 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o.rd !== e.rd || o.busy !== e.busy)
                $display("FAIL %s port%0d: got rd=%h rbusy=%b, expected rd=%h rbusy=%b",
                         e.nm, e.port, o.rd, o.busy, e.rd, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_claim();
        chk_t e;
        chk_t o;
        @(negedge clk);
        bus.ra[0] = 5'd9;
        bus.claim_en = 1'b1; bus.claim_addr = 5'd9;
        #1;
        expect_port("claim_not_yet_busy", 0);
        cycle();
        expect_port("claim_busy", 0);
        @(negedge clk);
        bus.we[1] = 1'b1; bus.wa[1] = 5'd9; bus.wd[1] = 64'h55;
        #1;
        expect_port("write_clear_same_cycle", 0);
        cycle();
        expect_port("write_clears_busy", 0);
        @(negedge clk);
        bus.we[0] = 1'b1; bus.wa[0] = 5'd9; bus.wd[0] = 64'h77;
        bus.claim_en = 1'b1; bus.claim_addr = 5'd9;
        #1;
        expect_port("claim_and_write_same_cycle", 0);
        cycle();
        expect_port("claim_beats_write", 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o.rd !== e.rd || o.busy !== e.busy)
                $display("FAIL %s port%0d: got rd=%h rbusy=%b, expected rd=%h rbusy=%b",
                         e.nm, e.port, o.rd, o.busy, e.rd, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_multi_read();
        chk_t e;
        chk_t o;
        @(negedge clk);
        bus.we[0] = 1'b1; bus.wa[0] = 5'd12; bus.wd[0] = 64'hABC;
        bus.ra = {5'd12, 5'd12, 5'd12, 5'd12};
        cycle();
        for (int i = 0; i < NR; i++) expect_port("all_ports_same_addr", i);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o.rd !== e.rd || o.busy !== e.busy)
                $display("FAIL %s port%0d: got rd=%h rbusy=%b, expected rd=%h rbusy=%b",
                         e.nm, e.port, o.rd, o.busy, e.rd, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        chk_t e;
        chk_t o;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            bus.we = NW'($urandom_range(0, 3));
            for (int p = 0; p < NW; p++) begin
                bus.wa[p] = 5'($urandom_range(0, 31));
                bus.wd[p] = {$urandom, $urandom};
            end
            bus.claim_en   = ($urandom_range(0, 2) == 0);
            bus.claim_addr = 5'($urandom_range(0, 31));
            for (int i = 0; i < NR; i++)
                bus.ra[i] = ($urandom_range(0, 1) == 0) ? bus.wa[i % NW] : 5'($urandom_range(0, 31));
            #1;
            for (int i = 0; i < NR; i++) expect_port("random_pre_edge", i);
            cycle();
            for (int i = 0; i < NR; i++) expect_port("random_post_edge", i);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o.rd !== e.rd || o.busy !== e.busy)
                $display("FAIL %s port%0d: got rd=%h rbusy=%b, expected rd=%h rbusy=%b",
                         e.nm, e.port, o.rd, o.busy, e.rd, e.busy);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_zero_reg();
        test_write_conflict();
        test_claim();
        test_multi_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
